// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types used by the writeback stage slice
package ibex_pkg;
  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;
endpackage

// File: rtl/ibex_wb_stage_if.sv
// ibex_wb_stage_if: ID/EX, LSU and register-file signals around the writeback stage
interface ibex_wb_stage_if;
  logic                      en_wb_i;
  ibex_pkg::wb_instr_type_e  instr_type_wb_i;
  logic [31:0]               pc_id_i;
  logic                      instr_is_compressed_id_i;
  logic                      instr_perf_count_id_i;
  logic [4:0]                rf_waddr_id_i;
  logic [31:0]               rf_wdata_id_i;
  logic                      rf_we_id_i;
  logic [31:0]               rf_wdata_lsu_i;
  logic                      rf_we_lsu_i;
  logic                      lsu_resp_valid_i;
  logic                      lsu_resp_err_i;
  logic                      ready_wb_o;
  logic                      rf_write_wb_o;
  logic                      outstanding_load_wb_o;
  logic                      outstanding_store_wb_o;
  logic [31:0]               pc_wb_o;
  logic                      perf_instr_ret_wb_o;
  logic                      perf_instr_ret_compressed_wb_o;
  logic [4:0]                rf_waddr_wb_o;
  logic [31:0]               rf_wdata_wb_o;
  logic                      rf_we_wb_o;
  modport master (
    output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
           rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, rf_wdata_lsu_i, rf_we_lsu_i,
           lsu_resp_valid_i, lsu_resp_err_i,
    input  ready_wb_o, rf_write_wb_o, outstanding_load_wb_o, outstanding_store_wb_o, pc_wb_o,
           perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
           rf_we_wb_o
  );
  modport slave (
    input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
           rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, rf_wdata_lsu_i, rf_we_lsu_i,
           lsu_resp_valid_i, lsu_resp_err_i,
    output ready_wb_o, rf_write_wb_o, outstanding_load_wb_o, outstanding_store_wb_o, pc_wb_o,
           perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
           rf_we_wb_o
  );
endinterface

// File: rtl/ibex_wb_stage.sv
// ibex_wb_stage: writeback stage holding one retiring instruction until it completes
module ibex_wb_stage
  import ibex_pkg::*;
#(
  parameter bit WritebackStage = 1'b1
) (
  input logic            clk_i,
  input logic            rst_ni,
  ibex_wb_stage_if.slave wb
);
  if (WritebackStage) begin : g_wb_stage
    logic           wb_valid_q, compressed_q, perf_count_q, rf_we_q;
    logic           wb_done, ready, accept, is_other, lsu_err;
    wb_instr_type_e type_q;
    logic [31:0]    pc_q, rf_wdata_q;
    logic [4:0]     rf_waddr_q;
    assign is_other = type_q == WB_INSTR_OTHER;
    assign wb_done  = wb_valid_q & (is_other | wb.lsu_resp_valid_i);
    assign ready    = ~wb_valid_q | wb_done;
    assign accept   = wb.en_wb_i & ready;
    assign lsu_err  = wb.lsu_resp_valid_i & wb.lsu_resp_err_i;
    // Occupancy: a completion and a new hand-over in the same cycle keep the slot full
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) wb_valid_q <= 1'b0;
      else if (accept) wb_valid_q <= 1'b1;
      else if (wb_done) wb_valid_q <= 1'b0;
    // Payload is captured on hand-over only and left stale once the slot empties
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        type_q       <= WB_INSTR_LOAD;
        pc_q         <= '0;
        compressed_q <= 1'b0;
        perf_count_q <= 1'b0;
        rf_waddr_q   <= '0;
        rf_wdata_q   <= '0;
        rf_we_q      <= 1'b0;
      end else if (accept) begin
        type_q       <= wb.instr_type_wb_i;
        pc_q         <= wb.pc_id_i;
        compressed_q <= wb.instr_is_compressed_id_i;
        perf_count_q <= wb.instr_perf_count_id_i;
        rf_waddr_q   <= wb.rf_waddr_id_i;
        rf_wdata_q   <= wb.rf_wdata_id_i;
        rf_we_q      <= wb.rf_we_id_i;
      end
    assign wb.ready_wb_o                     = ready;
    assign wb.rf_write_wb_o                  = wb_valid_q & rf_we_q & is_other;
    assign wb.outstanding_load_wb_o          = wb_valid_q & (type_q == WB_INSTR_LOAD);
    assign wb.outstanding_store_wb_o         = wb_valid_q & (type_q == WB_INSTR_STORE);
    assign wb.pc_wb_o                        = pc_q;
    assign wb.perf_instr_ret_wb_o            = wb_done & perf_count_q & ~lsu_err;
    assign wb.perf_instr_ret_compressed_wb_o = wb_done & perf_count_q & ~lsu_err & compressed_q;
    assign wb.rf_waddr_wb_o                  = rf_waddr_q;
    assign wb.rf_wdata_wb_o                  = wb.rf_we_lsu_i ? wb.rf_wdata_lsu_i : rf_wdata_q;
    assign wb.rf_we_wb_o                     = (wb_valid_q & rf_we_q & is_other) | wb.rf_we_lsu_i;
    a_en_ready: assert property (@(posedge clk_i) disable iff (!rst_ni) wb.en_wb_i |-> ready);
    a_resp_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wb.lsu_resp_valid_i |-> wb_valid_q & ~is_other);
    a_lsu_we_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wb.rf_we_lsu_i |-> wb.lsu_resp_valid_i);
    a_type_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wb.en_wb_i |-> wb.instr_type_wb_i != 2'b11);
  end else begin : g_no_wb_stage
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, wb.instr_type_wb_i, wb.lsu_resp_valid_i, wb.lsu_resp_err_i};
    assign wb.ready_wb_o                     = 1'b1;
    assign wb.rf_write_wb_o                  = 1'b0;
    assign wb.outstanding_load_wb_o          = 1'b0;
    assign wb.outstanding_store_wb_o         = 1'b0;
    assign wb.pc_wb_o                        = wb.pc_id_i;
    assign wb.perf_instr_ret_wb_o            = wb.en_wb_i & wb.instr_perf_count_id_i;
    assign wb.perf_instr_ret_compressed_wb_o = wb.en_wb_i & wb.instr_perf_count_id_i &
                                               wb.instr_is_compressed_id_i;
    assign wb.rf_waddr_wb_o                  = wb.rf_waddr_id_i;
    assign wb.rf_wdata_wb_o                  = wb.rf_we_lsu_i ? wb.rf_wdata_lsu_i : wb.rf_wdata_id_i;
    assign wb.rf_we_wb_o                     = (wb.en_wb_i & wb.rf_we_id_i) | wb.rf_we_lsu_i;
  end
endmodule
